arb_mux: RTL and testbench
==========================

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter WIDTH, default 32, data width of every channel and of the output.
REQ-002 Parameter N, default 4, number of input channels; legal range 1..16.
REQ-003 Localparam SEL_W = max(1, clog2(N)); it is the width of the channel-index output.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-006 in_valid  input  N  per-channel request; bit i qualifies in_data[i].
REQ-007 in_data  input  N x WIDTH  per-channel payload, packed array indexed by channel.
REQ-008 in_ready  output  N  per-channel accept; at most one bit high per cycle.
REQ-009 out_valid  output  1  output register holds a valid word.
REQ-010 out_data  output  WIDTH  registered payload of the granted channel.
REQ-011 out_sel  output  SEL_W  index of the channel that supplied out_data.
REQ-012 out_ready  input  1  downstream accepts the current output word.

Function
REQ-013 Block SHALL be an N-way registered multiplexer with round-robin arbitration and valid/ready handshakes on all ports.
REQ-014 Transfer on channel i occurs when in_valid[i] and in_ready[i] are both high at a rising edge; output transfer when out_valid and out_ready are both high.
REQ-015 Output slot is free when out_valid is low or out_ready is high (same-cycle drain and refill allowed).
REQ-016 in_ready[i] SHALL be high only when the slot is free, in_valid[i] is high and i is the arbitration winner; in_ready is combinational from in_valid, out_valid, out_ready and the pointer.
REQ-017 Winner: first channel with in_valid high searching upward from (last_grant + 1) mod N, wrapping to 0.
REQ-018 On a channel transfer, out_data <= in_data[winner], out_sel <= winner, out_valid <= 1, last_grant <= winner, all in the same edge.
REQ-019 On output transfer with no channel transfer, out_valid <= 0; out_data and out_sel hold their values.
REQ-020 When the slot is not free (out_valid high, out_ready low), out_valid, out_data, out_sel and last_grant SHALL hold, and all in_ready bits are low.
REQ-021 Latency input-to-output is exactly 1 cycle; sustained throughput is one word per cycle when out_ready is held high.
REQ-022 No in_valid high: no transfer, last_grant unchanged.
REQ-023 Channel that wins is not re-granted while any other channel is valid (fairness: each valid channel is served within N transfers).
REQ-024 N = 1: arbiter degenerates; in_ready[0] = slot free, out_sel constant 0.
REQ-025 in_valid may drop without a handshake; no state is kept for unaccepted requests.

Reset
REQ-026 While rst_n is low at a rising edge: out_valid <= 0, out_data <= 0, out_sel <= 0, last_grant <= N-1 (so channel 0 has first priority after reset).
REQ-027 in_ready SHALL be all-zero during any cycle in which rst_n is low.
REQ-028 Reset mid-transfer discards the output word; no transfer completes in the reset cycle.

Structure
REQ-029 Shared package mux_pkg SHALL hold the SEL_W computation function and the max-channel constant (16).
REQ-030 Round-robin winner logic SHALL be a separate combinational sub-module rr_arbiter (inputs req[N], last_grant; outputs grant one-hot, grant index, any).
REQ-031 Output register and handshake logic SHALL remain in arb_mux.

Verification
REQ-032 Reset: hold rst_n low 2 cycles with all in_valid high -> out_valid 0, out_data 0, out_sel 0, in_ready 0000.
REQ-033 Single request: N=4, in_valid=0100, in_data[2]=0xDEADBEEF, out_ready=1 -> in_ready=0100, next cycle out_valid 1, out_data 0xDEADBEEF, out_sel 2.
REQ-034 Round robin: in_valid=1111 held, out_ready=1, data[i]=i+0x10 -> out_sel sequence 0,1,2,3,0 on consecutive cycles.
REQ-035 Back-pressure: out_valid 1 with out_sel 1, out_ready=0 for 3 cycles, in_valid=1111 -> in_ready 0000, out_data stable; on out_ready=1 next grant is channel 2.
REQ-036 Skip idle: last_grant=3, in_valid=0010 -> grant channel 1; then in_valid=0011 -> grant channel 0 after channel 1 (wrap from 1 picks 0 only when 2,3 idle... pointer starts at 2, wraps to 0).
REQ-037 Reset mid-stream: assert rst_n low while out_valid 1, out_ready 0 -> out_valid 0 next edge; after release with in_valid=1111 first grant is channel 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared sizing helpers for the arbitrated multiplexer family.
package mux_pkg;

   localparam int MAX_CH = 16;

   // Channel-index width; a one-channel mux still carries a 1-bit index.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after last_grant, wrapping.
// No state; the owner of last_grant decides when a grant is consumed.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter int N     = 4,
   parameter int SEL_W = sel_width(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] last_grant,
   output logic [N-1:0]     grant,
   output logic [SEL_W-1:0] grant_idx,
   output logic             any
);

   always_comb begin
      int lg;
      lg        = 0;
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      lg        = int'(last_grant);
      // Offset N lands back on last_grant itself, so it only wins when it is the sole requester.
      for (int off = 1; off <= N; off++) begin
         for (int i = 0; i < N; i++) begin
            if (!any && (i == ((lg + off) % N)) && req[i]) begin
               any       = 1'b1;
               grant[i]  = 1'b1;
               grant_idx = SEL_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/arb_mux.sv
// N-way round-robin mux into a single output register; 1-cycle latency, one word/cycle.
// Backpressure: a held output word blocks every channel until it drains (same-cycle refill allowed).
module arb_mux
   import mux_pkg::*;
#(
   parameter int  WIDTH = 32,
   parameter int  N     = 4,
   localparam int SEL_W = sel_width(N)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N-1:0]            in_valid,
   input  logic [N-1:0][WIDTH-1:0] in_data,
   output logic [N-1:0]            in_ready,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   input  logic                    out_ready
);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0] out_sel_q, out_sel_d;
   logic [SEL_W-1:0] last_grant_q, last_grant_d;

   logic [N-1:0]     grant;
   logic [SEL_W-1:0] grant_idx;
   logic             grant_any;
   logic             slot_free;
   logic             in_xfer;
   logic             out_xfer;
   logic [WIDTH-1:0] win_data;

   rr_arbiter #(
      .N     (N),
      .SEL_W (SEL_W)
   ) u_arb (
      .req        (in_valid),
      .last_grant (last_grant_q),
      .grant      (grant),
      .grant_idx  (grant_idx),
      .any        (grant_any)
   );

   assign slot_free = ~out_valid_q | out_ready;
   assign in_ready  = (rst_n && slot_free) ? grant : '0;
   assign in_xfer   = rst_n & slot_free & grant_any;
   assign out_xfer  = out_valid_q & out_ready;

   // One-hot AND-OR select keeps the payload path free of index-width corner cases.
   always_comb begin
      win_data = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) begin
            win_data = win_data | in_data[i];
         end
      end
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_sel_d    = out_sel_q;
      last_grant_d = last_grant_q;
      if (in_xfer) begin
         out_valid_d  = 1'b1;
         out_data_d   = win_data;
         out_sel_d    = grant_idx;
         last_grant_d = grant_idx;
      end else if (out_xfer) begin
         out_valid_d  = 1'b0;
      end
   end

   // last_grant resets to N-1 so channel 0 is first in line.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_sel_q    <= '0;
         last_grant_q <= SEL_W'(N - 1);
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_sel_q    <= out_sel_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: directed cycle table, then random traffic against a queue-free behavioural model.
module tb_arb_mux;

   typedef struct {
      logic        rst;
      logic [3:0]  v;
      logic        ordy;
      logic [31:0] db;
      logic [3:0]  rdy;
      logic        ov;
      logic [1:0]  os;
      logic [31:0] od;
   } vec_t;

   logic             clk;
   logic             rst_n;
   logic [3:0]       in_valid;
   logic [3:0][31:0] in_data;
   logic [3:0]       in_ready;
   logic             out_valid;
   logic [31:0]      out_data;
   logic [1:0]       out_sel;
   logic             out_ready;

   logic [0:0][7:0]  d1;
   logic [0:0]       ir1;
   logic             ov1;
   logic [7:0]       od1;
   logic [0:0]       os1;

   int checks = 0;
   int errors = 0;

   // Reference state: what the output register and round-robin pointer should hold.
   logic        m_ov;
   logic [31:0] m_od;
   int          m_os;
   int          m_lg;
   logic        m1_ov;
   logic [7:0]  m1_od;

   vec_t tbl [28];

   arb_mux #(.WIDTH(32), .N(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   assign d1[0] = in_data[0][7:0];

   arb_mux #(.WIDTH(8), .N(1)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[0:0]),
      .in_data   (d1),
      .in_ready  (ir1),
      .out_valid (ov1),
      .out_data  (od1),
      .out_sel   (os1),
      .out_ready (out_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [3:0] v, input int lg);
      for (int k = 1; k <= 4; k++) begin
         int c;
         c = (lg + k) % 4;
         if (v[2'(c)]) return c;
      end
      return -1;
   endfunction

   function automatic logic [3:0] model_ready();
      int w;
      w = rr_pick(in_valid, m_lg);
      if (!rst_n || (m_ov && !out_ready) || w < 0) return 4'b0000;
      return 4'(4'b0001 << w);
   endfunction

   task automatic model_step();
      int w;
      logic [3:0] rdy;
      logic       rdy1;
      rdy  = model_ready();
      w    = rr_pick(in_valid, m_lg);
      rdy1 = rst_n && in_valid[0] && (!m1_ov || out_ready);
      if (!rst_n) begin
         m_ov = 1'b0; m_od = '0; m_os = 0; m_lg = 3;
      end else if (rdy != 4'b0000) begin
         m_ov = 1'b1; m_od = in_data[2'(w)]; m_os = w; m_lg = w;
      end else if (out_ready) begin
         m_ov = 1'b0;
      end
      if (!rst_n) begin
         m1_ov = 1'b0; m1_od = '0;
      end else if (rdy1) begin
         m1_ov = 1'b1; m1_od = in_data[0][7:0];
      end else if (out_ready) begin
         m1_ov = 1'b0;
      end
   endtask

   task automatic run_cycle(input vec_t t, input bit use_tbl);
      logic [3:0] e_rdy;
      @(negedge clk);
      rst_n     = t.rst;
      in_valid  = t.v;
      out_ready = t.ordy;
      for (int i = 0; i < 4; i++) in_data[i] = t.db + 32'(i);
      #1;
      e_rdy = use_tbl ? t.rdy : model_ready();
      chk("in_ready", 32'(in_ready), 32'(e_rdy));
      chk("n1_in_ready", 32'(ir1), 32'(rst_n && in_valid[0] && (!m1_ov || out_ready)));
      @(posedge clk);
      model_step();
      #1;
      if (use_tbl) begin
         chk("out_valid", 32'(out_valid), 32'(t.ov));
         chk("out_sel", 32'(out_sel), 32'(t.os));
         chk("out_data", out_data, t.od);
      end else begin
         chk("rnd_out_valid", 32'(out_valid), 32'(m_ov));
         chk("rnd_out_sel", 32'(out_sel), 32'(m_os));
         chk("rnd_out_data", out_data, m_od);
      end
      chk("n1_out_valid", 32'(ov1), 32'(m1_ov));
      chk("n1_out_data", 32'(od1), 32'(m1_od));
      chk("n1_out_sel", 32'(os1), 32'd0);
   endtask

   initial begin
      vec_t r;
      int   served [4];
      rst_n = 1'b0; in_valid = '0; out_ready = 1'b0; in_data = '0;
      m_ov = 1'b0; m_od = '0; m_os = 0; m_lg = 3; m1_ov = 1'b0; m1_od = '0;

      //             rst v        ordy db            rdy      ov  os  od
      tbl[0]  = '{1'b0, 4'b1111, 1'b1, 32'h100,      4'b0000, 1'b0, 2'd0, 32'h0};
      tbl[1]  = '{1'b0, 4'b1111, 1'b1, 32'h100,      4'b0000, 1'b0, 2'd0, 32'h0};
      tbl[2]  = '{1'b1, 4'b0100, 1'b1, 32'hDEADBEED, 4'b0100, 1'b1, 2'd2, 32'hDEADBEEF};
      tbl[3]  = '{1'b1, 4'b1000, 1'b1, 32'h10,       4'b1000, 1'b1, 2'd3, 32'h13};
      tbl[4]  = '{1'b1, 4'b1111, 1'b1, 32'h10,       4'b0001, 1'b1, 2'd0, 32'h10};
      tbl[5]  = '{1'b1, 4'b1111, 1'b1, 32'h10,       4'b0010, 1'b1, 2'd1, 32'h11};
      tbl[6]  = '{1'b1, 4'b1111, 1'b1, 32'h10,       4'b0100, 1'b1, 2'd2, 32'h12};
      tbl[7]  = '{1'b1, 4'b1111, 1'b1, 32'h10,       4'b1000, 1'b1, 2'd3, 32'h13};
      tbl[8]  = '{1'b1, 4'b1111, 1'b1, 32'h10,       4'b0001, 1'b1, 2'd0, 32'h10};
      tbl[9]  = '{1'b1, 4'b1111, 1'b1, 32'h10,       4'b0010, 1'b1, 2'd1, 32'h11};
      tbl[10] = '{1'b1, 4'b1111, 1'b0, 32'h20,       4'b0000, 1'b1, 2'd1, 32'h11};
      tbl[11] = '{1'b1, 4'b1111, 1'b0, 32'h20,       4'b0000, 1'b1, 2'd1, 32'h11};
      tbl[12] = '{1'b1, 4'b1111, 1'b0, 32'h20,       4'b0000, 1'b1, 2'd1, 32'h11};
      tbl[13] = '{1'b1, 4'b1111, 1'b1, 32'h20,       4'b0100, 1'b1, 2'd2, 32'h22};
      tbl[14] = '{1'b1, 4'b0000, 1'b1, 32'h20,       4'b0000, 1'b0, 2'd2, 32'h22};
      tbl[15] = '{1'b1, 4'b1000, 1'b1, 32'h20,       4'b1000, 1'b1, 2'd3, 32'h23};
      tbl[16] = '{1'b1, 4'b0010, 1'b1, 32'h30,       4'b0010, 1'b1, 2'd1, 32'h31};
      tbl[17] = '{1'b1, 4'b0011, 1'b1, 32'h30,       4'b0001, 1'b1, 2'd0, 32'h30};
      tbl[18] = '{1'b1, 4'b0011, 1'b1, 32'h30,       4'b0010, 1'b1, 2'd1, 32'h31};
      tbl[19] = '{1'b1, 4'b1111, 1'b0, 32'h30,       4'b0000, 1'b1, 2'd1, 32'h31};
      tbl[20] = '{1'b0, 4'b1111, 1'b0, 32'h30,       4'b0000, 1'b0, 2'd0, 32'h0};
      tbl[21] = '{1'b1, 4'b1111, 1'b1, 32'h40,       4'b0001, 1'b1, 2'd0, 32'h40};
      tbl[22] = '{1'b1, 4'b0000, 1'b0, 32'h40,       4'b0000, 1'b1, 2'd0, 32'h40};
      tbl[23] = '{1'b1, 4'b0100, 1'b0, 32'h40,       4'b0000, 1'b1, 2'd0, 32'h40};
      tbl[24] = '{1'b1, 4'b0100, 1'b1, 32'h40,       4'b0100, 1'b1, 2'd2, 32'h42};
      tbl[25] = '{1'b1, 4'b0000, 1'b0, 32'h40,       4'b0000, 1'b1, 2'd2, 32'h42};
      tbl[26] = '{1'b1, 4'b0000, 1'b1, 32'h40,       4'b0000, 1'b0, 2'd2, 32'h42};
      tbl[27] = '{1'b1, 4'b0001, 1'b0, 32'h40,       4'b0001, 1'b1, 2'd0, 32'h40};

      for (int i = 0; i < 28; i++) run_cycle(tbl[i], 1'b1);

      // Sustained full load: every cycle must move a word, and 8 cycles serve each channel twice.
      for (int i = 0; i < 4; i++) served[i] = 0;
      for (int c = 0; c < 8; c++) begin
         r = '{1'b1, 4'b1111, 1'b1, 32'h500, 4'b0000, 1'b0, 2'd0, 32'h0};
         run_cycle(r, 1'b0);
         chk("full_rate_valid", 32'(out_valid), 32'd1);
         served[out_sel]++;
      end
      for (int i = 0; i < 4; i++) chk("fair_share", 32'(served[i]), 32'd2);

      for (int c = 0; c < 600; c++) begin
         r.rst  = ($urandom_range(0, 39) != 0);
         r.v    = 4'($urandom_range(0, 15));
         r.ordy = ($urandom_range(0, 3) != 0);
         r.db   = $urandom;
         run_cycle(r, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
